waterfall_capture_ctrl: RTL and testbench

- Sequences ADC sample capture into a ping-pong (two-bank) line buffer, frame-locked to the LCD driver's frame-start pulse.
- Each frame, one full line of decimated ADC samples is written into the write bank. At the next frame start, the banks swap and the completed line is handed to the display/waterfall path.
- Sits between the ADC front-end (ready/data) and the line-buffer RAM. Runs in the pixel clock domain.

---
 rtl/waterfall_capture_ctrl.sv | 140 ++++++++++++++
 tb/tb_waterfall_capture_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/waterfall_capture_ctrl.sv
// Frame-locked ADC line capture into a ping-pong line buffer.
// One decimated line is written per frame; at the next frame start the banks
// swap and the finished line becomes readable on rd_bank.
module waterfall_capture_ctrl #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int LINE_LEN     = 480,
  parameter int ADDR_W       = 9,
  parameter int DECIM        = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    frame_start,
  input  logic                    adc_ready,
  input  logic [SAMPLE_WIDTH-1:0] adc_data,
  input  logic                    clr_overrun,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [SAMPLE_WIDTH-1:0] wr_data,
  output logic                    wr_bank,
  output logic                    rd_bank,
  output logic                    line_valid,
  output logic                    overrun,
  output logic                    busy
);

  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);
  localparam logic [DEC_W-1:0]  DEC_MAX   = DEC_W'(DECIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAP, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [DEC_W-1:0]  r_dec;
  logic              r_wr_bank;
  logic              r_swap_pend;

  logic w_cap, w_tick, w_hit, w_fin, w_ovr, w_accept, w_dswap, w_restart;

  // Event decode. Abort (enable low) suppresses any write in that cycle.
  // A non-final sample coincident with frame_start is dropped by the restart.
  assign w_cap     = (r_state == S_CAP);
  assign w_tick    = w_cap & enable & adc_ready;
  assign w_hit     = w_tick & (r_dec == '0);
  assign w_fin     = w_hit & (r_cnt == LAST_ADDR);
  assign w_ovr     = w_cap & enable & frame_start & ~w_fin;
  assign w_accept  = w_hit & ~w_ovr;
  assign w_dswap   = (r_state == S_DONE) & frame_start;
  assign w_restart = ((r_state == S_ARM) & enable & frame_start) | w_ovr |
                     w_dswap | (w_fin & frame_start);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (enable) w_next = S_ARM;
      S_ARM: begin
        if (!enable)          w_next = S_IDLE;
        else if (frame_start) w_next = S_CAP;
      end
      S_CAP: begin
        if (!enable)                  w_next = S_IDLE;
        else if (w_fin & ~frame_start) w_next = S_DONE;
      end
      S_DONE: begin
        if (frame_start)  w_next = enable ? S_CAP : S_IDLE;
        else if (!enable) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = (r_state == S_CAP);
  end

  // Sample and decimation counters; every line (re)start begins at address 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_dec <= '0;
    end else if (w_restart) begin
      r_cnt <= '0;
      r_dec <= '0;
    end else begin
      if (w_tick)   r_dec <= (r_dec == DEC_MAX) ? '0 : r_dec + 1'b1;
      if (w_accept) r_cnt <= (r_cnt == LAST_ADDR) ? '0 : r_cnt + 1'b1;
    end
  end

  // Registered write port; address and data hold between strobes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= w_accept;
      if (w_accept) begin
        wr_addr <= r_cnt;
        wr_data <= adc_data;
      end
    end
  end

  // Bank swap. When the final sample meets frame_start, the swap is held one
  // cycle so the last write still lands in the pre-swap bank.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_bank   <= 1'b0;
      r_swap_pend <= 1'b0;
      line_valid  <= 1'b0;
    end else begin
      r_swap_pend <= w_fin & frame_start;
      if (w_dswap | r_swap_pend) begin
        r_wr_bank  <= ~r_wr_bank;
        line_valid <= 1'b1;
      end
    end
  end

  // Sticky overrun; a new overrun beats a simultaneous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          overrun <= 1'b0;
    else if (w_ovr)       overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  assign wr_bank = r_wr_bank;
  assign rd_bank = ~r_wr_bank;

endmodule

// File: tb/tb_waterfall_capture_ctrl.sv
// Directed bench: one DECIM=1 and one DECIM=3 instance (LINE_LEN=4) share
// stimulus; a negedge monitor logs each write as {bank, addr, data}.
module tb_waterfall_capture_ctrl;
  localparam int SW = 12;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic resetn, enable, frame_start, adc_ready, clr_overrun;
  logic [SW-1:0] adc_data;

  logic          d1_wr_en, d1_wr_bank, d1_rd_bank, d1_lv, d1_ovr, d1_busy;
  logic [AW-1:0] d1_wr_addr;
  logic [SW-1:0] d1_wr_data;
  logic          d3_wr_en, d3_wr_bank, d3_rd_bank, d3_lv, d3_ovr, d3_busy;
  logic [AW-1:0] d3_wr_addr;
  logic [SW-1:0] d3_wr_data;

  int checks = 0;
  int errors = 0;
  logic [21:0] q1[$];
  logic [21:0] q3[$];

  always #5 clk = ~clk;

  waterfall_capture_ctrl #(.SAMPLE_WIDTH(SW), .LINE_LEN(4), .ADDR_W(AW), .DECIM(1)) u_d1 (
    .clk(clk), .resetn(resetn), .enable(enable), .frame_start(frame_start),
    .adc_ready(adc_ready), .adc_data(adc_data), .clr_overrun(clr_overrun),
    .wr_en(d1_wr_en), .wr_addr(d1_wr_addr), .wr_data(d1_wr_data),
    .wr_bank(d1_wr_bank), .rd_bank(d1_rd_bank), .line_valid(d1_lv),
    .overrun(d1_ovr), .busy(d1_busy));

  waterfall_capture_ctrl #(.SAMPLE_WIDTH(SW), .LINE_LEN(4), .ADDR_W(AW), .DECIM(3)) u_d3 (
    .clk(clk), .resetn(resetn), .enable(enable), .frame_start(frame_start),
    .adc_ready(adc_ready), .adc_data(adc_data), .clr_overrun(clr_overrun),
    .wr_en(d3_wr_en), .wr_addr(d3_wr_addr), .wr_data(d3_wr_data),
    .wr_bank(d3_wr_bank), .rd_bank(d3_rd_bank), .line_valid(d3_lv),
    .overrun(d3_ovr), .busy(d3_busy));

  always @(negedge clk) begin
    if (resetn && d1_wr_en) q1.push_back({d1_wr_bank, d1_wr_addr, d1_wr_data});
    if (resetn && d3_wr_en) q3.push_back({d3_wr_bank, d3_wr_addr, d3_wr_data});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; enable = 1'b0; frame_start = 1'b0; adc_ready = 1'b0;
    adc_data = '0; clr_overrun = 1'b0;
    repeat (2) cyc();
    resetn = 1'b1;
    cyc();
    q1.delete(); q3.delete();
  endtask

  // enable, wait in ARM, then frame_start into CAPTURE
  task automatic arm_start();
    enable = 1'b1; cyc();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
  endtask

  task automatic adc(input logic [SW-1:0] d);
    adc_ready = 1'b1; adc_data = d; cyc();
    adc_ready = 1'b0; cyc();
  endtask

  task automatic chk_wr(input string tag, input logic [21:0] e,
                        input logic b, input int a, input int d);
    chk({tag, ".bank"}, 32'(e[21]), 32'(b));
    chk({tag, ".addr"}, 32'(e[20:12]), 32'(a));
    chk({tag, ".data"}, 32'(e[11:0]), 32'(d));
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst.wr_en", 32'(d1_wr_en), 0);
    chk("rst.wr_addr", 32'(d1_wr_addr), 0);
    chk("rst.wr_data", 32'(d1_wr_data), 0);
    chk("rst.wr_bank", 32'(d1_wr_bank), 0);
    chk("rst.rd_bank", 32'(d1_rd_bank), 1);
    chk("rst.line_valid", 32'(d1_lv), 0);
    chk("rst.overrun", 32'(d1_ovr), 0);
    chk("rst.busy", 32'(d1_busy), 0);

    // T1: basic line, then swap
    enable = 1'b1; cyc();
    chk("t1.arm_busy", 32'(d1_busy), 0);
    fs_pulse();
    chk("t1.cap_busy", 32'(d1_busy), 1);
    for (int i = 0; i < 4; i++) adc(SW'(12'h101 + i));
    chk("t1.nwr", q1.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr($sformatf("t1.w%0d", i), q1[i], 1'b0, i, 12'h101 + i);
    chk("t1.done_busy", 32'(d1_busy), 0);
    chk("t1.pre_bank", 32'(d1_wr_bank), 0);
    fs_pulse();
    chk("t1.wr_bank", 32'(d1_wr_bank), 1);
    chk("t1.rd_bank", 32'(d1_rd_bank), 0);
    chk("t1.line_valid", 32'(d1_lv), 1);
    chk("t1.ovr0", 32'(d1_ovr), 0);
    chk("t1.d3_ovr", 32'(d3_ovr), 1);
    chk("t1.d3_bank", 32'(d3_wr_bank), 0);

    // T2: DECIM=3 keeps samples 0,3,6,9
    do_reset();
    arm_start();
    for (int i = 0; i < 12; i++) adc(SW'(i));
    chk("t2.nwr", q3.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr($sformatf("t2.w%0d", i), q3[i], 1'b0, i, 3 * i);
    chk("t2.done_busy", 32'(d3_busy), 0);

    // T3: overrun after 2 samples, restart in same bank, then clear
    do_reset();
    arm_start();
    adc(12'h011); adc(12'h012);
    fs_pulse();
    chk("t3.ovr", 32'(d1_ovr), 1);
    chk("t3.bank", 32'(d1_wr_bank), 0);
    chk("t3.lv", 32'(d1_lv), 0);
    chk("t3.busy", 32'(d1_busy), 1);
    q1.delete();
    for (int i = 0; i < 4; i++) adc(SW'(12'h201 + i));
    chk("t3.nwr", q1.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr($sformatf("t3.w%0d", i), q1[i], 1'b0, i, 12'h201 + i);
    chk("t3.ovr_held", 32'(d1_ovr), 1);
    clr_overrun = 1'b1; cyc(); clr_overrun = 1'b0;
    chk("t3.ovr_clr", 32'(d1_ovr), 0);

    // T4: final sample coincident with frame_start
    do_reset();
    arm_start();
    for (int i = 0; i < 3; i++) adc(SW'(12'h301 + i));
    adc_ready = 1'b1; adc_data = 12'h304; frame_start = 1'b1; cyc();
    adc_ready = 1'b0; frame_start = 1'b0;
    chk("t4.wr_en", 32'(d1_wr_en), 1);
    chk("t4.addr", 32'(d1_wr_addr), 3);
    chk("t4.bank_old", 32'(d1_wr_bank), 0);
    cyc();
    chk("t4.bank_new", 32'(d1_wr_bank), 1);
    chk("t4.rd_bank", 32'(d1_rd_bank), 0);
    chk("t4.lv", 32'(d1_lv), 1);
    chk("t4.ovr", 32'(d1_ovr), 0);
    chk("t4.busy", 32'(d1_busy), 1);
    adc(12'h355);
    chk("t4.nwr", q1.size(), 5);
    chk_wr("t4.w3", q1[3], 1'b0, 3, 12'h304);
    chk_wr("t4.w4", q1[4], 1'b1, 0, 12'h355);

    // T5: abort mid-line; adc_ready in the abort cycle is not written
    do_reset();
    arm_start();
    adc(12'h401); adc(12'h402);
    q1.delete();
    enable = 1'b0; adc_ready = 1'b1; adc_data = 12'h4ff; cyc(); adc_ready = 1'b0;
    chk("t5.busy", 32'(d1_busy), 0);
    adc(12'h403); adc(12'h404);
    chk("t5.nwr", q1.size(), 0);
    chk("t5.bank", 32'(d1_wr_bank), 0);
    chk("t5.addr_hold", 32'(d1_wr_addr), 1);
    arm_start();
    adc(12'h405);
    chk("t5.nwr2", q1.size(), 1);
    chk_wr("t5.w0", q1[0], 1'b0, 0, 12'h405);

    // T6: async reset between edges, with bank 1 and a write in flight
    do_reset();
    arm_start();
    for (int i = 0; i < 4; i++) adc(SW'(i + 1));
    fs_pulse();
    adc(12'h501);
    adc_ready = 1'b1; adc_data = 12'h502; cyc(); adc_ready = 1'b0;
    chk("t6.pre_wr_en", 32'(d1_wr_en), 1);
    chk("t6.pre_bank", 32'(d1_wr_bank), 1);
    #2 resetn = 1'b0;
    #1;
    chk("t6.wr_en", 32'(d1_wr_en), 0);
    chk("t6.wr_addr", 32'(d1_wr_addr), 0);
    chk("t6.wr_data", 32'(d1_wr_data), 0);
    chk("t6.wr_bank", 32'(d1_wr_bank), 0);
    chk("t6.rd_bank", 32'(d1_rd_bank), 1);
    chk("t6.lv", 32'(d1_lv), 0);
    chk("t6.ovr", 32'(d1_ovr), 0);
    chk("t6.busy", 32'(d1_busy), 0);
    cyc();
    resetn = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
